data_write_buffer: RTL and testbench
====================================

# data_write_buffer

Posted-write buffer between the data cache's memory port and the data memory.
- Accepts cache write-backs (6-bit block address, 32-bit block) into a DEPTH-entry FIFO and drains them to memory in the background.
- Coalesces repeated writes to the same block.
- Forwards buffered data to read misses and lets non-conflicting reads bypass queued writes.
- The cache sees one-cycle writes instead of full memory latency.

## Interface
Parameters
- DEPTH, 4: FIFO entries (power of two, ≥2)
- ADDR_W, 6: block address width
- DATA_W, 32: block data width

Ports
- CLK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-low (0 = reset)
- C_READ  in  1  cache block-read request
- C_WRITE  in  1  cache block-write request
- C_ADDRESS  in  ADDR_W  request block address
- C_WRITEDATA  in  DATA_W  write block
- C_READDATA  out  DATA_W  read block returned to cache
- C_BUSYWAIT  out  1  request not yet complete
- MEM_READ  out  1  memory read strobe
- MEM_WRITE  out  1  memory write strobe
- MEM_ADDRESS  out  ADDR_W  memory block address
- MEM_WRITEDATA  out  DATA_W  memory write block
- MEM_READDATA  in  DATA_W  memory read block
- MEM_BUSYWAIT  in  1  memory busy
- WB_EMPTY  out  1  no entries queued and no drain in flight

## Operation
- **Storage:** DEPTH entries of {addr, data}, head/tail pointers mod DEPTH, count 0..DEPTH.
- **Drain FSM:** states IDLE, DRAIN, READ.
  - IDLE → READ if a read miss is pending (read has priority).
  - Otherwise IDLE → DRAIN if count > 0.
  - DRAIN drives MEM_WRITE=1, MEM_ADDRESS/MEM_WRITEDATA = head entry.
  - READ drives MEM_READ=1, MEM_ADDRESS = C_ADDRESS.
- **Memory completion:** first rising edge where MEM_BUSYWAIT=0, provided the state has been held for at least one full cycle. This covers memories that assert busywait one edge late.
  - DRAIN completion: pop head, → IDLE.
  - READ completion: load MEM_READDATA into rdata register, set rd_done, → IDLE.
  - IDLE always lasts ≥1 cycle with MEM_READ=MEM_WRITE=0.
- **Write acceptance:** a write is accepted on a rising edge with C_WRITE=1 and C_BUSYWAIT=0.
  - Coalesce: if C_ADDRESS matches a valid entry that is not the head under active DRAIN, overwrite that entry's data; count unchanged.
  - Otherwise push at tail.
  - C_BUSYWAIT = C_WRITE & full & no coalesce target (combinational).
- **Read forward:** if C_ADDRESS matches any valid entry, C_READDATA = newest matching entry's data (combinationally) and C_BUSYWAIT=0. A draining head counts as a match.
- **Read miss:** C_BUSYWAIT=1 until rd_done. C_READDATA = rdata while rd_done=1. rd_done clears at the next rising edge.
- **Illegal input:** C_READ & C_WRITE both high: the write is ignored and the cycle is treated as a read.
- **Simultaneous push and pop** on one edge: both take effect; count unchanged.
- **Full:** a write to a non-matching address stalls until a pop. The push happens on the first edge after the pop, never on the pop edge itself.
- **Reset (RESET=0, asynchronous):**
  - Pointers and count clear; state = IDLE; rd_done=0; rdata=0.
  - MEM_READ=MEM_WRITE=0; WB_EMPTY=1; C_BUSYWAIT follows its equation with count=0.
  - Queued writes are discarded.
  - A reset during DRAIN or READ abandons the transaction immediately.

## Timing
- Write, not full or coalescing: 0 stall cycles; entry visible to forwarding from the next cycle.
- Read forward hit: 0 stall cycles.
- Read miss with memory idle: C_BUSYWAIT high for 1 (IDLE) + memory latency + 1 (rd_done) cycles. An in-flight drain adds its remaining cycles plus 1 IDLE.
- Reads never wait for non-matching queued writes beyond a drain already in flight.
- WB_EMPTY is registered: it rises in the cycle after the last pop.
- MEM_* outputs are registered off state and head and are stable for the whole transaction.

## Test plan
- **Reset:** hold RESET=0 mid-DRAIN → MEM_WRITE=0 immediately, WB_EMPTY=1, C_BUSYWAIT=0 with idle inputs; no later memory write occurs.
- **Burst to full:** 5 writes to addresses 0x01..0x05 (data 0xA1..0xA5), memory latency 5.
  - First 4 complete with no stall.
  - The 5th stalls until the pop of 0x01.
  - Memory receives 0x01..0x05 in order, each with matching data.
- **Coalesce:** write 0x08=0x11, then 0x09=0x22, then 0x09=0x33 while 0x08 drains → count stays 2; memory sees 0x09=0x33 only once.
- **Forward:** queue 0x10=0xDEADBEEF, then read 0x10 → C_READDATA=0xDEADBEEF with C_BUSYWAIT=0 the same cycle; no MEM_READ issued.
- **Bypass:** queue 0x20 and 0x21, then read 0x30 during the 0x20 drain.
  - MEM_READ(0x30) is issued after the 0x20 completion and before any write of 0x21.
  - C_READDATA equals the memory contents.
- **Draining-head match:** read 0x20 while 0x20 is under DRAIN and a newer 0x20 entry holds 0x55 → returns 0x55.

Source files
------------

// File: rtl/data_write_buffer_if.sv
// Cache-side and memory-side signals of the posted-write buffer.
//   slave  : view taken by data_write_buffer (consumes cache requests and
//            memory responses, drives cache responses and memory strobes).
//   master : view taken by the surrounding cache/memory environment.
interface data_write_buffer_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
);
  logic              C_READ;
  logic              C_WRITE;
  logic [ADDR_W-1:0] C_ADDRESS;
  logic [DATA_W-1:0] C_WRITEDATA;
  logic [DATA_W-1:0] C_READDATA;
  logic              C_BUSYWAIT;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [DATA_W-1:0] MEM_WRITEDATA;
  logic [DATA_W-1:0] MEM_READDATA;
  logic              MEM_BUSYWAIT;
  logic              WB_EMPTY;

  modport slave (
    input  C_READ, C_WRITE, C_ADDRESS, C_WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output C_READDATA, C_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS,
           MEM_WRITEDATA, WB_EMPTY
  );

  modport master (
    output C_READ, C_WRITE, C_ADDRESS, C_WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  C_READDATA, C_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS,
           MEM_WRITEDATA, WB_EMPTY
  );
endinterface

// File: rtl/data_write_buffer.sv
// Posted-write buffer between the data cache and data memory.
// Cache writes land in a DEPTH-entry FIFO (with same-block coalescing) and
// are drained to memory in the background; reads are forwarded from the
// FIFO when they hit, otherwise they bypass queued writes to memory.
// Ports:
//   CLK   : clock, rising edge
//   RESET : asynchronous reset, active low
//   bus   : cache request/response and memory strobe/response signals
module data_write_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input logic                CLK,
  input logic                RESET,
  data_write_buffer_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, READ} state_e;

  state_e            state_q, state_d;
  logic              armed_q, armed_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rd_done_q, rd_done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wb_empty_q, wb_empty_d;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  lk_idx;
  logic              rd_hit, wr_hit;
  logic [DATA_W-1:0] rd_hit_data;
  logic [PTR_W-1:0]  wr_hit_idx;
  logic              full, wr_req, wr_accept, push, coalesce, pop, done, read_pending;

  // Associative lookup over valid entries, oldest to newest so the newest match wins.
  // The head under active drain may serve reads but must not absorb new writes.
  always_comb begin
    lk_idx      = '0;
    rd_hit      = 1'b0;
    rd_hit_data = '0;
    wr_hit      = 1'b0;
    wr_hit_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      lk_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_mem[lk_idx] == bus.C_ADDRESS)) begin
        rd_hit      = 1'b1;
        rd_hit_data = data_mem[lk_idx];
        if (!((i == 0) && (state_q == DRAIN))) begin
          wr_hit     = 1'b1;
          wr_hit_idx = lk_idx;
        end
      end
    end
  end

  // Request decode; a simultaneous read and write is handled as a read only.
  assign full         = (count_q == CNT_W'(DEPTH));
  assign wr_req       = bus.C_WRITE & ~bus.C_READ;
  assign wr_accept    = wr_req & ~(full & ~wr_hit);
  assign coalesce     = wr_accept & wr_hit;
  assign push         = wr_accept & ~wr_hit;
  assign read_pending = bus.C_READ & ~rd_hit & ~rd_done_q;
  // armed_q holds off completion on the first edge so a late busywait is not missed.
  assign done         = (state_q != IDLE) & armed_q & ~bus.MEM_BUSYWAIT;
  assign pop          = (state_q == DRAIN) & done;

  assign bus.C_BUSYWAIT  = bus.C_READ ? (~rd_hit & ~rd_done_q)
                                      : (bus.C_WRITE & full & ~wr_hit);
  assign bus.C_READDATA  = rd_done_q ? rdata_q : rd_hit_data;
  assign bus.MEM_READ      = mem_read_q;
  assign bus.MEM_WRITE     = mem_write_q;
  assign bus.MEM_ADDRESS   = mem_addr_q;
  assign bus.MEM_WRITEDATA = mem_wdata_q;
  assign bus.WB_EMPTY      = wb_empty_q;

  // Drain/read FSM next state and registered memory-port values.
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    rd_done_d   = 1'b0;
    rdata_d     = rdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        armed_d = 1'b0;
        if (read_pending) begin
          state_d    = READ;
          mem_read_d = 1'b1;
          mem_addr_d = bus.C_ADDRESS;
        end else if (count_q != '0) begin
          state_d     = DRAIN;
          mem_write_d = 1'b1;
          mem_addr_d  = addr_mem[head_q];
          // A write coalescing into the head on this same edge must reach memory.
          mem_wdata_d = (coalesce && (wr_hit_idx == head_q)) ? bus.C_WRITEDATA
                                                              : data_mem[head_q];
        end
      end
      DRAIN: begin
        armed_d = 1'b1;
        if (done) begin
          state_d     = IDLE;
          armed_d     = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      READ: begin
        armed_d = 1'b1;
        if (done) begin
          state_d    = IDLE;
          armed_d    = 1'b0;
          mem_read_d = 1'b0;
          rdata_d    = bus.MEM_READDATA;
          rd_done_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        armed_d     = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    head_d     = head_q + PTR_W'(pop);
    tail_d     = tail_q + PTR_W'(push);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    wb_empty_d = (count_d == '0);
  end

  // Control and output registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rd_done_q   <= 1'b0;
      rdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_empty_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rd_done_q   <= rd_done_d;
      rdata_q     <= rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_empty_q  <= wb_empty_d;
    end
  end

  // Entry storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[tail_q] <= bus.C_ADDRESS;
      data_mem[tail_q] <= bus.C_WRITEDATA;
    end
    if (coalesce) begin
      data_mem[wr_hit_idx] <= bus.C_WRITEDATA;
    end
  end

endmodule

// File: tb/tb_data_write_buffer.sv
module tb_data_write_buffer;

  logic clk;
  logic rst;

  data_write_buffer_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  data_write_buffer #(.DEPTH(4), .ADDR_W(6), .DATA_W(32)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- memory model (busywait rises one edge after the strobe) ----
  typedef struct packed {
    logic        wr;
    logic [5:0]  a;
    logic [31:0] d;
  } mlog_t;

  logic [31:0] memarr [64];
  mlog_t       mlog [$];
  int          lat_cfg  = 3;
  bit          lat_rand = 1'b0;
  int          mem_cnt;
  logic        mem_cool;
  logic        mem_op_wr;
  logic [5:0]  mem_a;
  logic [31:0] mem_d;

  function automatic logic [31:0] init_val(input int a);
    return 32'hC0DE0000 | 32'(a);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.MEM_BUSYWAIT <= 1'b0;
      bus.MEM_READDATA <= '0;
      mem_cnt          <= 0;
      mem_cool         <= 1'b0;
    end else if (bus.MEM_BUSYWAIT) begin
      if (mem_cnt <= 1) begin
        bus.MEM_BUSYWAIT <= 1'b0;
        mem_cool         <= 1'b1;
        if (mem_op_wr) memarr[mem_a] <= mem_d;
        else           bus.MEM_READDATA <= memarr[mem_a];
      end else begin
        mem_cnt <= mem_cnt - 1;
      end
    end else if (mem_cool) begin
      mem_cool <= 1'b0;
    end else if (bus.MEM_READ || bus.MEM_WRITE) begin
      bus.MEM_BUSYWAIT <= 1'b1;
      mem_cnt   <= lat_rand ? int'($urandom_range(1, 4)) : lat_cfg;
      mem_op_wr <= bus.MEM_WRITE;
      mem_a     <= bus.MEM_ADDRESS;
      mem_d     <= bus.MEM_WRITEDATA;
      mlog.push_back(mlog_t'({bus.MEM_WRITE, bus.MEM_ADDRESS, bus.MEM_WRITEDATA}));
    end
  end

  // ---------------- reference: latest value written per block -----------------
  logic [31:0] golden [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cache request, held until accepted; returns read data and stall count.
  task automatic do_op(input bit rd, input bit wr, input logic [5:0] a,
                       input logic [31:0] d, output logic [31:0] rdata,
                       output int stalls);
    bit fin;
    bus.C_READ      = rd;
    bus.C_WRITE     = wr;
    bus.C_ADDRESS   = a;
    bus.C_WRITEDATA = d;
    stalls = 0;
    rdata  = '0;
    fin    = 1'b0;
    while (!fin) begin
      @(negedge clk);
      if (!bus.C_BUSYWAIT) begin
        rdata = bus.C_READDATA;
        fin   = 1'b1;
      end else begin
        stalls++;
        if (stalls > 300) begin
          checks++;
          failures++;
          $display("FAIL op_timeout: addr %0h still busy after %0d cycles", a, stalls);
          fin = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    bus.C_READ  = 1'b0;
    bus.C_WRITE = 1'b0;
    if (wr && !rd && stalls <= 300) golden[a] = d;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.WB_EMPTY && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: WB_EMPTY got 0 expected 1");
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          max_stall;   // -1: stall not checked
  } vec_t;

  vec_t vecs [10];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] rdv;
    int          st;
    int          base;
    int          nreads;
    int          bad;

    vecs[0] = '{1'b0, 1'b1, 6'h10, 32'hDEADBEEF, 32'h0,        0};
    vecs[1] = '{1'b1, 1'b0, 6'h10, 32'h0,        32'hDEADBEEF, 0};
    vecs[2] = '{1'b0, 1'b1, 6'h11, 32'h12345678, 32'h0,        0};
    vecs[3] = '{1'b1, 1'b0, 6'h11, 32'h0,        32'h12345678, 0};
    vecs[4] = '{1'b0, 1'b1, 6'h10, 32'hCAFEF00D, 32'h0,        0};
    vecs[5] = '{1'b1, 1'b0, 6'h10, 32'h0,        32'hCAFEF00D, 0};
    vecs[6] = '{1'b1, 1'b1, 6'h11, 32'h0BADBAD0, 32'h12345678, 0};
    vecs[7] = '{1'b1, 1'b0, 6'h12, 32'h0,        32'hC0DE0012, -1};
    vecs[8] = '{1'b1, 1'b0, 6'h11, 32'h0,        32'h12345678, -1};
    vecs[9] = '{1'b1, 1'b0, 6'h10, 32'h0,        32'hCAFEF00D, -1};

    for (int i = 0; i < 64; i++) begin
      memarr[i] = init_val(i);
      golden[i] = init_val(i);
    end

    rst = 1'b0;
    bus.C_READ = 1'b0;
    bus.C_WRITE = 1'b0;
    bus.C_ADDRESS = '0;
    bus.C_WRITEDATA = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_write", 64'(bus.MEM_WRITE), 64'd0);
    chk("reset_mem_read",  64'(bus.MEM_READ),  64'd0);
    chk("reset_wb_empty",  64'(bus.WB_EMPTY),  64'd1);
    chk("reset_busywait",  64'(bus.C_BUSYWAIT), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Burst to full: fifth write stalls until the first entry drains.
    lat_cfg = 5;
    base = mlog.size();
    for (int i = 1; i <= 5; i++) begin
      do_op(1'b0, 1'b1, 6'(i), 32'hA0 + 32'(i), rdv, st);
      if (i <= 4) chk("burst_nostall", 64'(st), 64'd0);
      else        chk("burst5_stalled", 64'(st > 0), 64'd1);
    end
    wait_empty();
    chk("burst_log_count", 64'(mlog.size() - base), 64'd5);
    for (int i = 0; i < 5; i++)
      if (base + i < mlog.size())
        chk("burst_log_entry", 64'(mlog[base + i]),
            64'({1'b1, 6'(i + 1), 32'hA1 + 32'(i)}));

    // Coalesce into a non-head entry while the head drains.
    base = mlog.size();
    do_op(1'b0, 1'b1, 6'h08, 32'h11, rdv, st);
    do_op(1'b0, 1'b1, 6'h09, 32'h22, rdv, st);
    do_op(1'b0, 1'b1, 6'h09, 32'h33, rdv, st);
    chk("coalesce_nostall", 64'(st), 64'd0);
    wait_empty();
    chk("coalesce_log_count", 64'(mlog.size() - base), 64'd2);
    if (mlog.size() - base >= 2) begin
      chk("coalesce_first",  64'(mlog[base]),     64'({1'b1, 6'h08, 32'h11}));
      chk("coalesce_second", 64'(mlog[base + 1]), 64'({1'b1, 6'h09, 32'h33}));
    end

    // Bypass: a read miss overtakes a queued non-matching write.
    base = mlog.size();
    do_op(1'b0, 1'b1, 6'h20, 32'hAAAA0020, rdv, st);
    do_op(1'b0, 1'b1, 6'h21, 32'hAAAA0021, rdv, st);
    do_op(1'b1, 1'b0, 6'h30, 32'h0, rdv, st);
    chk("bypass_rdata", 64'(rdv), 64'(golden[6'h30]));
    wait_empty();
    chk("bypass_log_count", 64'(mlog.size() - base), 64'd3);
    if (mlog.size() - base >= 3) begin
      chk("bypass_w20", 64'({mlog[base].wr, mlog[base].a}),         64'({1'b1, 6'h20}));
      chk("bypass_r30", 64'({mlog[base + 1].wr, mlog[base + 1].a}), 64'({1'b0, 6'h30}));
      chk("bypass_w21", 64'({mlog[base + 2].wr, mlog[base + 2].a}), 64'({1'b1, 6'h21}));
    end

    // Draining head matches but a newer copy of the block holds fresher data.
    do_op(1'b0, 1'b1, 6'h20, 32'h11, rdv, st);
    do_op(1'b0, 1'b1, 6'h21, 32'h99, rdv, st);
    do_op(1'b0, 1'b1, 6'h20, 32'h55, rdv, st);
    do_op(1'b1, 1'b0, 6'h20, 32'h0, rdv, st);
    chk("head_match_rdata", 64'(rdv), 64'h55);
    chk("head_match_stall", 64'(st), 64'd0);
    wait_empty();
    chk("head_match_mem", 64'(memarr[6'h20]), 64'h55);

    // Table of single requests with expected data and stall limits.
    lat_cfg = 3;
    for (int i = 0; i < 10; i++) begin
      nreads = 0;
      foreach (mlog[k]) if (!mlog[k].wr) nreads++;
      do_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdv, st);
      if (vecs[i].rd) chk($sformatf("vec%0d_rdata", i), 64'(rdv), 64'(vecs[i].exp_rdata));
      if (vecs[i].max_stall >= 0) begin
        chk($sformatf("vec%0d_stall", i), 64'(st), 64'(vecs[i].max_stall));
        bad = 0;
        foreach (mlog[k]) if (!mlog[k].wr) bad++;
        if (vecs[i].rd) chk($sformatf("vec%0d_no_memread", i), 64'(bad - nreads), 64'd0);
      end
    end
    wait_empty();

    // Reset mid-drain abandons the queued write.
    lat_cfg = 5;
    do_op(1'b0, 1'b1, 6'h3F, 32'hBAD0BAD0, rdv, st);
    st = 0;
    @(negedge clk);
    while (!bus.MEM_WRITE && st < 50) begin
      @(negedge clk);
      st++;
    end
    chk("reset_drain_started", 64'(bus.MEM_WRITE), 64'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_mem_write", 64'(bus.MEM_WRITE),  64'd0);
    chk("rst_mid_wb_empty",  64'(bus.WB_EMPTY),   64'd1);
    chk("rst_mid_busywait",  64'(bus.C_BUSYWAIT), 64'd0);
    base = mlog.size();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("rst_no_late_write", 64'(mlog.size() - base), 64'd0);
    chk("rst_mem_untouched", 64'(memarr[6'h3F]), 64'(init_val(63)));

    // Randomized traffic against the latest-value reference.
    lat_rand = 1'b1;
    for (int i = 0; i < 64; i++) golden[i] = memarr[i];
    for (int n = 0; n < 400; n++) begin
      int          r;
      logic [5:0]  a;
      logic [31:0] d;
      r = int'($urandom_range(0, 9));
      a = 6'(24 + $urandom_range(0, 7));
      d = $urandom;
      if (r < 5) begin
        do_op(1'b0, 1'b1, a, d, rdv, st);
      end else if (r < 9) begin
        do_op(1'b1, (r == 8), a, d, rdv, st);
        chk("rand_read", 64'(rdv), 64'(golden[a]));
      end else begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_empty();
    bad = 0;
    for (int i = 0; i < 64; i++) if (memarr[i] !== golden[i]) bad++;
    chk("rand_final_mem", 64'(bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
